uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 2-flop input synchronizer,
// mid-bit sampling, level rx_valid with ack, parity/frame/overrun status.
// Ports: CLOCK_50, rst_n (async low), rx (serial in), rx_ack (consumer ack)
//        rx_data[7:0], rx_valid, parity_err, frame_err, overrun_err, busy.
// Build option: define UART_RX_PARITY_EN for an 11-bit frame with odd
// parity; otherwise a 10-bit frame is expected and parity_err stays 0.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 1000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          deliver;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          perr_w;

  // Synchronizer resets to the idle level so reset never looks like a start.
  assign rx_s = sync_q[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // armed_q: line must be seen high in IDLE before a falling
  // edge counts as a start bit (no retrigger on a stuck-low line).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    armed_d = armed_q;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Odd parity: data bits plus parity bit must hold an odd count of ones.
  assign perr_w = ~(^shift_q ^ par_q);
`else
  assign perr_w = 1'b0;
`endif

  // Delivery beats a same-cycle ack: the byte stays valid, no overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (deliver) begin
      data_d  = shift_q;
      perr_d  = perr_w;
      ferr_d  = ~rx_s;
      valid_d = 1'b1;
      if (rx_ack) begin
        ovr_d = 1'b0;
      end else if (valid_q) begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule
